// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path.
// Glyph table is common to the encoder and the scan monitor.
package seg7_pkg;

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}, indexed by hex value.
    localparam logic [6:0] SEG7_GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_SETTLE,
        SCAN_HELD
    } scan_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Reverse lookup of an active-low segment pattern to a hex nibble.
// Exact match only; anything else reports ok=0.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       ok,
    output logic       blank
);

    always_comb begin
        nibble = 4'h0;
        ok     = 1'b0;
        blank  = (pattern == SEG7_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG7_GLYPH[i]) begin
                nibble = 4'(i);
                ok     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_monitor.sv
// Passive monitor of a multiplexed 4-digit 7-segment display.
// Captures each digit once stable and reports a value per full scan.
module seg7_scan_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an_n,
    input  logic [6:0]  seg_n,
    output logic [15:0] digits,
    output logic [3:0]  digit_ok,
    output logic [3:0]  digit_blank,
    output logic        frame_valid,
    output logic [15:0] value,
    output logic        frame_err,
    output logic        stale
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [8:0] STABLE = 9'(STABLE_CYCLES);

    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    scan_state_t   state;
    logic [1:0]    lat_idx;
    logic [6:0]    lat_pat;
    logic [7:0]    count;
    logic          single;
    logic [1:0]    idx;
    logic          same;
    logic          relatch;
    logic          cap;
    logic [3:0]    cap_mask;
    logic [6:0]    pick;
    logic [3:0]    nib;
    logic          ok;
    logic          blank;
    logic [3:0]    seen;
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= 4'hF;
            seg_q <= SEG7_BLANK;
        end else begin
            an_q  <= an_n;
            seg_q <= seg_n;
        end
    end

    always_comb begin
        single = 1'b1;
        idx    = 2'd0;
        unique case (1'b1)
            (an_q == 4'b1110): idx = 2'd0;
            (an_q == 4'b1101): idx = 2'd1;
            (an_q == 4'b1011): idx = 2'd2;
            (an_q == 4'b0111): idx = 2'd3;
            default:           single = 1'b0;
        endcase
        same    = single && (idx == lat_idx) && (seg_q == lat_pat);
        relatch = single && ((state == SCAN_IDLE) || !same);
        cap     = 1'b0;
        if (single) begin
            if (relatch)
                cap = (STABLE == 9'd1);
            else
                cap = (state == SCAN_SETTLE)
                   && (({1'b0, count} + 9'd1) == STABLE);
        end
        cap_mask = cap ? (4'b0001 << idx) : 4'b0000;
        pick     = relatch ? seg_q : lat_pat;
    end

    seg7_to_hex u_dec (
        .pattern (pick),
        .nibble  (nib),
        .ok      (ok),
        .blank   (blank)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SCAN_IDLE;
            lat_idx <= 2'd0;
            lat_pat <= 7'd0;
            count   <= 8'd0;
        end else if (!single) begin
            state <= SCAN_IDLE;
            count <= 8'd0;
        end else if (relatch) begin
            lat_idx <= idx;
            lat_pat <= seg_q;
            count   <= 8'd1;
            state   <= cap ? SCAN_HELD : SCAN_SETTLE;
        end else if (state == SCAN_SETTLE) begin
            count <= count + 8'd1;
            if (cap)
                state <= SCAN_HELD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits      <= 16'd0;
            digit_ok    <= 4'd0;
            digit_blank <= 4'd0;
            frame_valid <= 1'b0;
            value       <= 16'd0;
            frame_err   <= 1'b0;
            stale       <= 1'b0;
            seen        <= 4'd0;
            idle_cnt    <= '0;
        end else begin
            frame_valid <= (seen == 4'hF);
            if (seen == 4'hF) begin
                value     <= digits;
                frame_err <= |(~digit_ok & ~digit_blank);
            end
            // A capture landing on the clear starts the next frame.
            seen <= ((seen == 4'hF) ? 4'h0 : seen) | cap_mask;
            if (cap) begin
                digits[{idx, 2'b00} +: 4] <= nib;
                digit_ok[idx]             <= ok;
                digit_blank[idx]          <= blank;
                idle_cnt                  <= '0;
                stale                     <= 1'b0;
            end else if (idle_cnt != TMAX) begin
                idle_cnt <= idle_cnt + TW'(1);
                stale    <= ((idle_cnt + TW'(1)) == TMAX);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Randomized and directed bench for seg7_scan_monitor.
// Reference model tracks run lengths of identical pin samples.
module tb_seg7_scan_monitor;

    localparam int S = 8;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic [15:0] digits;
    logic [3:0]  digit_ok;
    logic [3:0]  digit_blank;
    logic        frame_valid;
    logic [15:0] value;
    logic        frame_err;
    logic        stale;

    always #5 clk = ~clk;

    seg7_scan_monitor #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .digits      (digits),
        .digit_ok    (digit_ok),
        .digit_blank (digit_blank),
        .frame_valid (frame_valid),
        .value       (value),
        .frame_err   (frame_err),
        .stale       (stale)
    );

    logic [6:0] glyph [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] m_digits;
    logic [3:0]  m_ok;
    logic [3:0]  m_blank;
    logic [3:0]  m_seen;
    logic        m_fv;
    logic [15:0] m_value;
    logic        m_err;
    logic        m_stale;
    int          m_idle;
    int          run;
    int          last_idx;
    logic [6:0]  last_seg;
    bit          pend;
    int          pend_idx;
    logic [6:0]  pend_seg;

    // Advance the model by one clock edge with the pins present at it.
    task automatic model_edge(input bit r, input logic [3:0] a,
                              input logic [6:0] sg);
        int zeros;
        int k;
        bit full;
        logic [3:0] nb;
        bit ok;
        if (r) begin
            m_digits = 0; m_ok = 0; m_blank = 0; m_seen = 0;
            m_fv = 0; m_value = 0; m_err = 0; m_stale = 0;
            m_idle = 0; run = 0; pend = 0;
            return;
        end
        full = (m_seen == 4'hF);
        m_fv = full;
        if (full) begin
            m_value = m_digits;
            m_err = |(~m_ok & ~m_blank);
            m_seen = 0;
        end
        if (pend) begin
            nb = 0; ok = 0;
            for (int i = 0; i < 16; i++)
                if (glyph[i] == pend_seg) begin nb = 4'(i); ok = 1; end
            m_digits[pend_idx*4 +: 4] = nb;
            m_ok[pend_idx] = ok;
            m_blank[pend_idx] = (pend_seg == 7'h7F);
            m_seen[pend_idx] = 1'b1;
            m_idle = 0;
            m_stale = 0;
        end else if (m_idle < T) begin
            m_idle++;
            m_stale = (m_idle == T);
        end
        zeros = 0; k = 0;
        for (int i = 0; i < 4; i++)
            if (!a[i]) begin zeros++; k = i; end
        if (zeros == 1) begin
            if (run > 0 && k == last_idx && sg == last_seg) run++;
            else run = 1;
            last_idx = k;
            last_seg = sg;
        end else begin
            run = 0;
        end
        pend = (zeros == 1) && (run == S);
        pend_idx = k;
        pend_seg = sg;
    endtask

    task automatic tick(input bit r, input logic [3:0] a,
                        input logic [6:0] sg);
        reset = r; an_n = a; seg_n = sg;
        @(posedge clk);
        model_edge(r, a, sg);
        #1;
    endtask

    task automatic do_reset;
        tick(1, 4'hF, 7'h7F);
        tick(1, 4'hF, 7'h7F);
    endtask

    task automatic test_reset;
        tick(1, 4'($urandom), 7'($urandom));
        tick(1, 4'b1110, 7'h30);
        n_total++;
        if (digits !== 16'h0) $display("FAIL reset_digits got %h want 0", digits);
        else n_pass++;
        n_total++;
        if ({digit_ok, digit_blank} !== 8'h0)
            $display("FAIL reset_flags got %h want 0", {digit_ok, digit_blank});
        else n_pass++;
        n_total++;
        if ({frame_valid, value, frame_err, stale} !== 19'h0)
            $display("FAIL reset_frame got %h want 0",
                     {frame_valid, value, frame_err, stale});
        else n_pass++;
    endtask

    task automatic test_frame;
        logic [3:0] an_l [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] sg_l [4] = '{7'h30, 7'h21, 7'h06, 7'h0E};
        int pulses = 0;
        logic [15:0] v = 0;
        logic e = 1'bx;
        do_reset();
        for (int d = 0; d < 4; d++)
            for (int c = 0; c < S; c++) begin
                tick(0, an_l[d], sg_l[d]);
                if (frame_valid) begin pulses++; v = value; e = frame_err; end
            end
        for (int c = 0; c < 4; c++) begin
            tick(0, 4'hF, 7'h7F);
            if (frame_valid) begin pulses++; v = value; e = frame_err; end
        end
        n_total++;
        if (pulses != 1) $display("FAIL frame_pulses got %0d want 1", pulses);
        else n_pass++;
        n_total++;
        if (v !== 16'hFED3) $display("FAIL frame_value got %h want fed3", v);
        else n_pass++;
        n_total++;
        if (e !== 1'b0) $display("FAIL frame_err got %b want 0", e);
        else n_pass++;
        n_total++;
        if (value !== 16'hFED3 || digit_ok !== 4'hF)
            $display("FAIL frame_hold got %h/%h want fed3/f", value, digit_ok);
        else n_pass++;
    endtask

    task automatic test_multi_anode;
        int pulses = 0;
        for (int c = 0; c < 50; c++) begin
            tick(0, 4'b1100, 7'h24);
            if (frame_valid) pulses++;
        end
        n_total++;
        if (digits !== 16'hFED3 || pulses != 0)
            $display("FAIL multi_anode got %h/%0d want fed3/0", digits, pulses);
        else n_pass++;
    endtask

    task automatic test_short_hold;
        int pulses = 0;
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int d = 0; d < 4; d++)
                for (int c = 0; c < S - 1; c++) begin
                    tick(0, 4'(~(4'b0001 << d)), glyph[d+4]);
                    if (frame_valid) pulses++;
                end
        for (int c = 0; c < 3; c++) begin
            tick(0, 4'hF, 7'h7F);
            if (frame_valid) pulses++;
        end
        n_total++;
        if (digits !== 16'h0 || digit_ok !== 4'h0 || pulses != 0)
            $display("FAIL short_hold got %h/%h/%0d want 0/0/0",
                     digits, digit_ok, pulses);
        else n_pass++;
    endtask

    task automatic test_bad_glyph;
        logic [6:0] sg_l [4] = '{7'h40, 7'h7E, 7'h7F, 7'h79};
        logic [15:0] v = 16'hxxxx;
        logic e = 1'bx;
        logic [3:0] bl = 4'hx;
        logic [3:0] ok = 4'hx;
        do_reset();
        for (int d = 0; d < 4; d++)
            for (int c = 0; c < S; c++)
                tick(0, 4'(~(4'b0001 << d)), sg_l[d]);
        for (int c = 0; c < 4; c++) begin
            tick(0, 4'hF, 7'h7F);
            if (frame_valid) begin
                v = value; e = frame_err; bl = digit_blank; ok = digit_ok;
            end
        end
        n_total++;
        if (bl !== 4'b0100 || ok !== 4'b1001)
            $display("FAIL bad_flags got %b/%b want 0100/1001", bl, ok);
        else n_pass++;
        n_total++;
        if (e !== 1'b1) $display("FAIL bad_err got %b want 1", e);
        else n_pass++;
        n_total++;
        if (v !== 16'h1000) $display("FAIL bad_value got %h want 1000", v);
        else n_pass++;
    endtask

    task automatic test_resettle;
        do_reset();
        for (int c = 0; c < 10; c++) tick(0, 4'b1110, 7'h79);
        n_total++;
        if (digits[3:0] !== 4'h1) $display("FAIL resettle_a got %h want 1", digits[3:0]);
        else n_pass++;
        for (int c = 0; c < S; c++) tick(0, 4'b1110, 7'h24);
        n_total++;
        if (digits[3:0] !== 4'h1) $display("FAIL resettle_early got %h want 1", digits[3:0]);
        else n_pass++;
        tick(0, 4'b1110, 7'h24);
        n_total++;
        if (digits[3:0] !== 4'h2) $display("FAIL resettle_b got %h want 2", digits[3:0]);
        else n_pass++;
    endtask

    task automatic test_stale_reset;
        do_reset();
        for (int c = 0; c < T - 1; c++) tick(0, 4'hF, 7'h7F);
        n_total++;
        if (stale !== 1'b0) $display("FAIL stale_early got %b want 0", stale);
        else n_pass++;
        tick(0, 4'hF, 7'h7F);
        n_total++;
        if (stale !== 1'b1) $display("FAIL stale_set got %b want 1", stale);
        else n_pass++;
        for (int c = 0; c < 5; c++) tick(0, 4'hF, 7'h7F);
        n_total++;
        if (stale !== 1'b1) $display("FAIL stale_sat got %b want 1", stale);
        else n_pass++;
        for (int c = 0; c < 3; c++) tick(0, 4'b1011, 7'h06);
        tick(1, 4'b1011, 7'h06);
        n_total++;
        if ({digits, digit_ok, digit_blank, frame_valid, value, frame_err, stale} !== 43'h0)
            $display("FAIL mid_reset got %h want 0",
                     {digits, digit_ok, digit_blank, frame_valid, value, frame_err, stale});
        else n_pass++;
        for (int c = 0; c < S; c++) tick(0, 4'b1011, 7'h06);
        n_total++;
        if (digits !== 16'h0) $display("FAIL partial_kept got %h want 0", digits);
        else n_pass++;
        tick(0, 4'b1011, 7'h06);
        n_total++;
        if (digits !== 16'h0E00) $display("FAIL post_reset got %h want 0e00", digits);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [42:0] exp_v;
        logic [42:0] act_v;
        logic [3:0] a;
        logic [6:0] sg;
        int len;
        int kind;
        do_reset();
        for (int seg = 0; seg < 70; seg++) begin
            kind = $urandom_range(0, 19);
            a = 4'(~(4'b0001 << $urandom_range(0, 3)));
            if (kind >= 17) a = 4'($urandom);
            sg = glyph[$urandom_range(0, 15)];
            if (kind >= 11 && kind < 14) sg = 7'h7F;
            if (kind >= 14 && kind < 17) sg = 7'($urandom);
            len = $urandom_range(1, 13);
            for (int c = 0; c < len; c++) begin
                tick(($urandom_range(0, 199) == 0), a, sg);
                exp_v = {m_digits, m_ok, m_blank, m_fv, m_value, m_err, m_stale};
                act_v = {digits, digit_ok, digit_blank, frame_valid, value, frame_err, stale};
                n_total++;
                if (act_v !== exp_v)
                    $display("FAIL random_cycle got %h want %h", act_v, exp_v);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        an_n = 4'hF;
        seg_n = 7'h7F;
        test_reset();
        test_frame();
        test_multi_anode();
        test_short_hold();
        test_bad_glyph();
        test_resettle();
        test_stale_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
